// File: rtl/rx_uart.sv
// Oversampling 8N1 / 8E1 serial receiver: a two-flop synchronizer, then one down-counter
// that times every mid-bit sample from the detected start edge.
module rx_uart #(
    parameter int   clockFreq = 25000000,
    parameter int   baudRate  = 115200,
    parameter logic if_parity = 1'b0
) (
    input  logic       i_clk,
    input  logic       rst,
    input  logic       i_uart_rx,
    output logic       o_wr,
    output logic [7:0] o_data
);

    localparam int          N        = clockFreq / baudRate;
    localparam int          H        = N / 2;
    localparam logic [15:0] N_RELOAD = 16'(N - 1);
    localparam logic [15:0] H_RELOAD = 16'(H - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t      state, state_nxt;
    logic        rx_m, rx_s, rx_p;
    logic [15:0] cnt, cnt_nxt;
    logic [2:0]  bit_idx, bit_nxt;
    logic [7:0]  shreg, sh_nxt;
    logic        perr, perr_nxt;
    logic        wr_nxt;
    logic [7:0]  data_nxt;
    logic        tick;

    // rx_p lags rx_s by one cycle so IDLE can see a 1 -> 0 transition
    always_ff @(posedge i_clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_p <= 1'b1;
        end else begin
            rx_m <= i_uart_rx;
            rx_s <= rx_m;
            rx_p <= rx_s;
        end
    end

    always_ff @(posedge i_clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 16'd0;
            bit_idx <= 3'd0;
            shreg   <= 8'h00;
            perr    <= 1'b0;
            o_wr    <= 1'b0;
            o_data  <= 8'h00;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_nxt;
            shreg   <= sh_nxt;
            perr    <= perr_nxt;
            o_wr    <= wr_nxt;
            o_data  <= data_nxt;
        end
    end

    assign tick = (cnt == 16'd0);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = tick ? cnt : cnt - 16'd1;
        bit_nxt   = bit_idx;
        sh_nxt    = shreg;
        perr_nxt  = perr;
        wr_nxt    = 1'b0;
        data_nxt  = o_data;
        case (state)
            IDLE: begin
                if (rx_p && !rx_s) begin
                    cnt_nxt   = H_RELOAD;
                    state_nxt = START;
                end
            end
            START: begin
                if (tick) begin
                    if (!rx_s) begin
                        state_nxt = DATA;
                        cnt_nxt   = N_RELOAD;
                        bit_nxt   = 3'd0;
                        perr_nxt  = 1'b0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    sh_nxt  = {rx_s, shreg[7:1]};
                    cnt_nxt = N_RELOAD;
                    if (bit_idx == 3'd7) begin
                        state_nxt = if_parity ? PARITY : STOP;
                    end else begin
                        bit_nxt = bit_idx + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    perr_nxt  = (^shreg) ^ rx_s;
                    cnt_nxt   = N_RELOAD;
                    state_nxt = STOP;
                end
            end
            STOP: begin
                // Leave at the stop-bit midpoint so a following start edge is not missed
                if (tick) begin
                    if (rx_s && !perr) begin
                        wr_nxt   = 1'b1;
                        data_nxt = shreg;
                    end
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_rx_uart.sv
// Bench for rx_uart: one receiver without parity and one with even parity, each on its own line.
`timescale 1ns/1ps
module tb_rx_uart;

    localparam int CLK_F = 25000000;
    localparam int BAUD  = 115200;
    localparam int N     = CLK_F / BAUD;
    localparam int H     = N / 2;
    localparam int LAT8  = 2 + H + 9 * N + 1;
    localparam int LAT9  = 2 + H + 10 * N + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx0 = 1'b1;
    logic       rx1 = 1'b1;
    logic       wr0, wr1;
    logic [7:0] d0, d1;

    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;
    int         hold_viol = 0;
    int         q0_cyc[$];
    int         q1_cyc[$];
    logic [7:0] q0_dat[$];
    logic [7:0] q1_dat[$];
    logic [7:0] prev0 = 8'h00;
    logic [7:0] prev1 = 8'h00;
    logic [7:0] exp0 = 8'h00;
    logic [7:0] exp1 = 8'h00;

    always #20 clk = ~clk;

    rx_uart #(.clockFreq(CLK_F), .baudRate(BAUD), .if_parity(1'b0)) dut0 (
        .i_clk(clk), .rst(rst), .i_uart_rx(rx0), .o_wr(wr0), .o_data(d0)
    );
    rx_uart #(.clockFreq(CLK_F), .baudRate(BAUD), .if_parity(1'b1)) dut1 (
        .i_clk(clk), .rst(rst), .i_uart_rx(rx1), .o_wr(wr1), .o_data(d1)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // A pulse seen after edge c is logged as cycle c+1, where a downstream flop latches it
    always @(negedge clk) begin
        if (wr0) begin q0_cyc.push_back(cyc + 1); q0_dat.push_back(d0); end
        if (wr1) begin q1_cyc.push_back(cyc + 1); q1_dat.push_back(d1); end
        if (!rst && !wr0 && d0 !== prev0) hold_viol++;
        if (!rst && !wr1 && d1 !== prev1) hold_viol++;
        prev0 = d0;
        prev1 = d1;
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic set_line(input int inst, input logic v);
        if (inst == 0) rx0 = v; else rx1 = v;
    endtask

    // Serial frame at N clocks per bit; s = index of the first edge that sees the start bit
    task automatic send(input int inst, input logic [7:0] data, input bit par_en,
                        input bit par_bit, input bit stop_bit, output int s);
        s = cyc + 1;
        set_line(inst, 1'b0);
        cycles(N);
        for (int k = 0; k < 8; k++) begin
            set_line(inst, data[k]);
            cycles(N);
        end
        if (par_en) begin
            set_line(inst, par_bit);
            cycles(N);
        end
        set_line(inst, stop_bit);
        cycles(N);
        set_line(inst, 1'b1);
    endtask

    function automatic bit accepted(input logic [7:0] data, input bit par_en,
                                    input bit par_bit, input bit stop_bit);
        int ones;
        ones = $countones(data) + (par_en ? int'(par_bit) : 0);
        return stop_bit && (!par_en || (ones % 2 == 0));
    endfunction

    function automatic bit even_par(input logic [7:0] data);
        return ($countones(data) % 2) != 0;
    endfunction

    task automatic clear_q();
        q0_cyc.delete(); q0_dat.delete();
        q1_cyc.delete(); q1_dat.delete();
    endtask

    task automatic test_reset();
        cycles(3);
        checks++; if (wr0 !== 1'b0) begin errors++; $display("FAIL reset_wr0 got=%b want=0", wr0); end
        checks++; if (d0 !== 8'h00) begin errors++; $display("FAIL reset_d0 got=%h want=00", d0); end
        checks++; if (wr1 !== 1'b0) begin errors++; $display("FAIL reset_wr1 got=%b want=0", wr1); end
        checks++; if (d1 !== 8'h00) begin errors++; $display("FAIL reset_d1 got=%h want=00", d1); end
        rst = 1'b0;
        cycles(2 * N);
        checks++;
        if (q0_cyc.size() + q1_cyc.size() != 0) begin
            errors++; $display("FAIL idle_pulses got=%0d want=0", q0_cyc.size() + q1_cyc.size());
        end
    endtask

    task automatic test_basic();
        int s;
        clear_q();
        send(0, 8'h41, 1'b0, 1'b0, 1'b1, s);
        cycles(20);
        checks++;
        if (q0_cyc.size() != 1) begin
            errors++; $display("FAIL basic_count got=%0d want=1", q0_cyc.size());
        end else begin
            checks++; if (q0_cyc[0] != s + LAT8) begin errors++; $display("FAIL basic_time got=%0d want=%0d", q0_cyc[0] - s, LAT8); end
            checks++; if (q0_dat[0] !== 8'h41) begin errors++; $display("FAIL basic_data got=%h want=41", q0_dat[0]); end
        end
        exp0 = 8'h41;
        checks++; if (d0 !== exp0) begin errors++; $display("FAIL basic_hold got=%h want=%h", d0, exp0); end
    endtask

    task automatic test_back_to_back();
        int s1, s2;
        clear_q();
        send(0, 8'h43, 1'b0, 1'b0, 1'b1, s1);
        send(0, 8'h44, 1'b0, 1'b0, 1'b1, s2);
        cycles(20);
        checks++;
        if (q0_cyc.size() != 2) begin
            errors++; $display("FAIL b2b_count got=%0d want=2", q0_cyc.size());
        end else begin
            checks++; if (q0_cyc[0] != s1 + LAT8) begin errors++; $display("FAIL b2b_time got=%0d want=%0d", q0_cyc[0] - s1, LAT8); end
            checks++; if (q0_cyc[1] - q0_cyc[0] != 10 * N) begin errors++; $display("FAIL b2b_gap got=%0d want=%0d", q0_cyc[1] - q0_cyc[0], 10 * N); end
            checks++; if (q0_dat[0] !== 8'h43) begin errors++; $display("FAIL b2b_data0 got=%h want=43", q0_dat[0]); end
            checks++; if (q0_dat[1] !== 8'h44) begin errors++; $display("FAIL b2b_data1 got=%h want=44", q0_dat[1]); end
        end
        exp0 = 8'h44;
        checks++; if (d0 !== exp0) begin errors++; $display("FAIL b2b_hold got=%h want=%h", d0, exp0); end
    endtask

    task automatic test_glitch();
        int s;
        clear_q();
        rx0 = 1'b0;
        cycles(50);
        rx0 = 1'b1;
        cycles(2 * N);
        checks++; if (q0_cyc.size() != 0) begin errors++; $display("FAIL glitch_count got=%0d want=0", q0_cyc.size()); end
        checks++; if (d0 !== exp0) begin errors++; $display("FAIL glitch_hold got=%h want=%h", d0, exp0); end
        send(0, 8'h42, 1'b0, 1'b0, 1'b1, s);
        cycles(20);
        checks++;
        if (q0_cyc.size() != 1) begin
            errors++; $display("FAIL glitch_next_count got=%0d want=1", q0_cyc.size());
        end else begin
            checks++; if (q0_dat[0] !== 8'h42) begin errors++; $display("FAIL glitch_next_data got=%h want=42", q0_dat[0]); end
        end
        exp0 = 8'h42;
    endtask

    task automatic test_stop_error();
        int s;
        clear_q();
        send(0, 8'h44, 1'b0, 1'b0, 1'b0, s);
        cycles(2 * N);
        checks++; if (q0_cyc.size() != 0) begin errors++; $display("FAIL stop_err_count got=%0d want=0", q0_cyc.size()); end
        checks++; if (d0 !== exp0) begin errors++; $display("FAIL stop_err_hold got=%h want=%h", d0, exp0); end
        send(0, 8'h41, 1'b0, 1'b0, 1'b1, s);
        cycles(20);
        checks++;
        if (q0_cyc.size() != 1) begin
            errors++; $display("FAIL stop_next_count got=%0d want=1", q0_cyc.size());
        end else begin
            checks++; if (q0_dat[0] !== 8'h41) begin errors++; $display("FAIL stop_next_data got=%h want=41", q0_dat[0]); end
        end
        exp0 = 8'h41;
    endtask

    task automatic test_parity();
        int s;
        clear_q();
        send(1, 8'h41, 1'b1, 1'b0, 1'b1, s);
        cycles(20);
        checks++;
        if (q1_cyc.size() != 1) begin
            errors++; $display("FAIL par_ok_count got=%0d want=1", q1_cyc.size());
        end else begin
            checks++; if (q1_cyc[0] != s + LAT9) begin errors++; $display("FAIL par_ok_time got=%0d want=%0d", q1_cyc[0] - s, LAT9); end
            checks++; if (q1_dat[0] !== 8'h41) begin errors++; $display("FAIL par_ok_data got=%h want=41", q1_dat[0]); end
        end
        exp1 = 8'h41;
        clear_q();
        send(1, 8'h41, 1'b1, 1'b1, 1'b1, s);
        cycles(20);
        checks++; if (q1_cyc.size() != 0) begin errors++; $display("FAIL par_bad_count got=%0d want=0", q1_cyc.size()); end
        checks++; if (d1 !== exp1) begin errors++; $display("FAIL par_bad_hold got=%h want=%h", d1, exp1); end
    endtask

    task automatic test_random();
        int s, want_n;
        logic [7:0] data;
        bit stop_bit, par_bit, ok;
        for (int i = 0; i < 6; i++) begin
            data = 8'($urandom);
            stop_bit = ($urandom_range(0, 4) != 0);
            ok = accepted(data, 1'b0, 1'b0, stop_bit);
            want_n = ok ? 1 : 0;
            clear_q();
            send(0, data, 1'b0, 1'b0, stop_bit, s);
            if (!stop_bit) cycles(2 * N);
            else cycles(5);
            if (ok) exp0 = data;
            checks++;
            if (q0_cyc.size() != want_n) begin
                errors++; $display("FAIL rand8n1_count[%0d] data=%h stop=%0d got=%0d want=%0d", i, data, stop_bit, q0_cyc.size(), want_n);
            end else if (ok) begin
                checks++; if (q0_cyc[0] != s + LAT8) begin errors++; $display("FAIL rand8n1_time[%0d] got=%0d want=%0d", i, q0_cyc[0] - s, LAT8); end
            end
            checks++; if (d0 !== exp0) begin errors++; $display("FAIL rand8n1_data[%0d] got=%h want=%h", i, d0, exp0); end
        end
        for (int i = 0; i < 5; i++) begin
            data = 8'($urandom);
            par_bit = ($urandom_range(0, 1) != 0) ? even_par(data) : !even_par(data);
            ok = accepted(data, 1'b1, par_bit, 1'b1);
            want_n = ok ? 1 : 0;
            clear_q();
            send(1, data, 1'b1, par_bit, 1'b1, s);
            cycles(5);
            if (ok) exp1 = data;
            checks++;
            if (q1_cyc.size() != want_n) begin
                errors++; $display("FAIL rand8e1_count[%0d] data=%h par=%0d got=%0d want=%0d", i, data, par_bit, q1_cyc.size(), want_n);
            end else if (ok) begin
                checks++; if (q1_cyc[0] != s + LAT9) begin errors++; $display("FAIL rand8e1_time[%0d] got=%0d want=%0d", i, q1_cyc[0] - s, LAT9); end
            end
            checks++; if (d1 !== exp1) begin errors++; $display("FAIL rand8e1_data[%0d] got=%h want=%h", i, d1, exp1); end
        end
    endtask

    task automatic test_reset_midframe();
        int s;
        clear_q();
        fork
            send(0, 8'h43, 1'b0, 1'b0, 1'b1, s);
            begin
                cycles(4 * N + N / 2);
                rst = 1'b1;
                #1;
                checks++; if (wr0 !== 1'b0) begin errors++; $display("FAIL midrst_wr got=%b want=0", wr0); end
                checks++; if (d0 !== 8'h00) begin errors++; $display("FAIL midrst_data got=%h want=00", d0); end
            end
        join
        cycles(10);
        rst = 1'b0;
        exp0 = 8'h00;
        exp1 = 8'h00;
        cycles(N);
        checks++; if (q0_cyc.size() != 0) begin errors++; $display("FAIL midrst_count got=%0d want=0", q0_cyc.size()); end
        clear_q();
        send(0, 8'h43, 1'b0, 1'b0, 1'b1, s);
        cycles(20);
        checks++;
        if (q0_cyc.size() != 1) begin
            errors++; $display("FAIL postrst_count got=%0d want=1", q0_cyc.size());
        end else begin
            checks++; if (q0_cyc[0] != s + LAT8) begin errors++; $display("FAIL postrst_time got=%0d want=%0d", q0_cyc[0] - s, LAT8); end
            checks++; if (q0_dat[0] !== 8'h43) begin errors++; $display("FAIL postrst_data got=%h want=43", q0_dat[0]); end
        end
        exp0 = 8'h43;
    endtask

    task automatic test_hold();
        checks++; if (hold_viol != 0) begin errors++; $display("FAIL data_hold got=%0d changes want=0", hold_viol); end
        checks++; if (d0 !== exp0) begin errors++; $display("FAIL final_d0 got=%h want=%h", d0, exp0); end
        checks++; if (d1 !== exp1) begin errors++; $display("FAIL final_d1 got=%h want=%h", d1, exp1); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_glitch();
        test_stop_error();
        test_parity();
        test_random();
        test_reset_midframe();
        test_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
